// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_pkg
// Description : Shared constants and the prefetch FIFO entry type for the
//               instruction fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    localparam int IMEM_AW = 11;
    localparam int INST_W  = 32;
    localparam int PC_W    = 32;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One prefetched instruction together with the byte address it came from.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_fifo
// Description : Circular buffer of fetch_entry_t with push, pop and a
//               synchronous flush. DEPTH must be a power of two (2..16) so
//               the pointers wrap without extra logic.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               wdata,
    output fetch_entry_t               rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);

    fetch_entry_t         r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wptr;
    logic [c_ptr_w-1:0]   r_rptr;
    logic [c_cnt_w-1:0]   r_count;

    // Storage write; entries need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; flush wins over push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue
// Description : Fetch stage owning the fetch PC. Drives the word address to a
//               combinational-read instruction memory, captures each word with
//               its PC into a prefetch FIFO and hands entries to decode over a
//               valid/ready handshake. A redirect flushes the FIFO and restarts
//               fetch at redirect_pc.
//               Optional macro IFETCH_STATS_EN adds the stall_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic [IMEM_AW-1:0] imem_a,
    input  logic [INST_W-1:0]  imem_rd,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INST_W-1:0]  inst,
    output logic [PC_W-1:0]    inst_pc
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    localparam int                 c_cnt_w = $clog2(DEPTH+1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);

    logic [PC_W-1:0]    r_fetch_pc;
    logic [c_cnt_w-1:0] w_count;
    fetch_entry_t       w_head;
    fetch_entry_t       w_wdata;
    logic               w_pop;
    logic               w_push;
    logic               w_full;

    assign inst_valid = (w_count != '0);
    assign w_full     = (w_count == c_full);
    assign w_pop      = inst_valid & inst_ready;
    // A full queue may still accept when the head leaves in the same cycle.
    assign w_push     = ~redirect & (~w_full | w_pop);

    assign imem_a        = r_fetch_pc[IMEM_AW+1:2];
    assign w_wdata.inst  = imem_rd;
    assign w_wdata.pc    = r_fetch_pc;

    // Outputs come only from FIFO storage, never straight from imem_rd.
    assign inst    = inst_valid ? w_head.inst : '0;
    assign inst_pc = inst_valid ? w_head.pc   : '0;

    // Fetch PC: redirect restarts at the word-aligned target, push advances.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc & ~32'd3;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect),
        .wdata (w_wdata),
        .rdata (w_head),
        .count (w_count)
    );

`ifdef IFETCH_STATS_EN
    logic [31:0] r_stall_cnt;

    // Count cycles where decode is ready but nothing is queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (inst_ready & ~inst_valid) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_queue
// Description : Self-checking bench for ifetch_queue. A per-cycle vector table
//               drives ready/redirect and checks inst_valid and imem_a; a
//               scoreboard of expected {inst, pc} pairs checks every transfer.
//               Hand-written sequences cover async reset and PC wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_valid;
        logic [10:0] exp_a;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] imem_a;
    logic [31:0] imem_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    logic [10:0] w_a;
    logic [31:0] w_rd;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_inst;
    logic [31:0] w_pc;

`ifdef IFETCH_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] w_stall_cnt;
    int          exp_stall;
`endif

    int   tests = 0;
    int   fails = 0;
    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    // Memory model: word k holds 0x1000_0000 + k.
    assign imem_rd = 32'h1000_0000 + {21'd0, imem_a};
    assign w_rd    = 32'h1000_0000 + {21'd0, w_a};

    ifetch_queue #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_a      (imem_a),
        .imem_rd     (imem_rd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
`ifdef IFETCH_STATS_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    ifetch_queue #(
        .RESET_PC (32'hFFFF_FFF8),
        .DEPTH    (4)
    ) u_wrap (
        .clk         (clk),
        .reset       (reset),
        .imem_a      (w_a),
        .imem_rd     (w_rd),
        .redirect    (w_redirect),
        .redirect_pc (w_redirect_pc),
        .inst_valid  (w_valid),
        .inst_ready  (w_ready),
        .inst        (w_inst),
        .inst_pc     (w_pc)
`ifdef IFETCH_STATS_EN
        ,
        .stall_cnt   (w_stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected delivery stream starting at a given byte address.
    task automatic load_stream(input logic [31:0] start);
        logic [31:0] pc;
        sb.delete();
        pc = start & ~32'd3;
        for (int i = 0; i < 64; i++) begin
            sb.push_back('{inst: 32'h1000_0000 + {21'd0, pc[12:2]}, pc: pc});
            pc = pc + 32'd4;
        end
    endtask

    task automatic add(input logic rdy, input logic rd, input logic [31:0] rpc,
                       input logic v, input logic [10:0] a);
        tbl.push_back('{ready: rdy, redir: rd, rpc: rpc, exp_valid: v, exp_a: a});
    endtask

    // Scoreboard: every transfer must match the next expected entry; a
    // redirect replaces the remaining expectation with the new target stream.
    always @(negedge clk) begin
        if (reset) begin
            load_stream(32'h0000_0000);
`ifdef IFETCH_STATS_EN
            exp_stall = 0;
`endif
        end else begin
`ifdef IFETCH_STATS_EN
            check("stall_cnt", stall_cnt, exp_stall);
            if (inst_ready && !inst_valid) exp_stall++;
`endif
            if (!inst_valid) begin
                check("idle_inst", inst, 32'd0);
                check("idle_pc", inst_pc, 32'd0);
            end else if (inst_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    check("xfer_pc", inst_pc, sb[0].pc);
                    check("xfer_inst", inst, sb[0].inst);
                    void'(sb.pop_front());
                end
            end
            if (redirect) load_stream(redirect_pc);
        end
    end

    initial begin
        reset         = 1'b1;
        redirect      = 1'b0;
        redirect_pc   = '0;
        inst_ready    = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = '0;
        w_ready       = 1'b1;

        // Backpressure from reset, then release.
        for (int r = 0; r < 10; r++) add(1'b0, 1'b0, 0, (r != 0), 11'((r < 4) ? r : 4));
        for (int r = 0; r < 8; r++)  add(1'b1, 1'b0, 0, 1'b1, 11'(4 + r));
        // Redirect with a pop while full, then build three entries.
        add(1'b1, 1'b1, 32'h103, 1'b1, 11'd12);
        add(1'b0, 1'b0, 0, 1'b0, 11'h40);
        add(1'b0, 1'b0, 0, 1'b1, 11'h41);
        add(1'b0, 1'b0, 0, 1'b1, 11'h42);
        // Redirect to 0x103 with three queued, no pop: bubble then 0x100.
        add(1'b0, 1'b1, 32'h103, 1'b1, 11'h43);
        add(1'b1, 1'b0, 0, 1'b0, 11'h40);
        add(1'b1, 1'b0, 0, 1'b1, 11'h41);
        add(1'b1, 1'b0, 0, 1'b1, 11'h42);
        add(1'b0, 1'b0, 0, 1'b1, 11'h43);
        add(1'b0, 1'b0, 0, 1'b1, 11'h44);
        // Redirect together with a pop: head completes, rest discarded.
        add(1'b1, 1'b1, 32'h200, 1'b1, 11'h45);
        add(1'b1, 1'b0, 0, 1'b0, 11'h80);
        add(1'b1, 1'b0, 0, 1'b1, 11'h81);
        add(1'b1, 1'b0, 0, 1'b1, 11'h82);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_pc", inst_pc, 32'd0);
        check("rst_imem_a", {21'd0, imem_a}, 32'd0);
        check("rst_wrap_a", {21'd0, w_a}, 32'h7FE);

        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            inst_ready  = tbl[i].ready;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            @(negedge clk);
            check($sformatf("row%0d_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].exp_valid});
            check($sformatf("row%0d_imem_a", i), {21'd0, imem_a}, {21'd0, tbl[i].exp_a});
            @(posedge clk);
            #1;
        end
        inst_ready = 1'b0;
        redirect   = 1'b0;

        // Asynchronous reset mid-stream, observed before the next clock edge.
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_valid", {31'd0, inst_valid}, 32'd0);
        check("async_inst", inst, 32'd0);
        check("async_pc", inst_pc, 32'd0);
        check("async_imem_a", {21'd0, imem_a}, 32'd0);
        check("async_wrap_a", {21'd0, w_a}, 32'h7FE);

        // PC wrap on the second instance, ready held high.
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("wrap0_a", {21'd0, w_a}, 32'h7FE);
        check("wrap0_valid", {31'd0, w_valid}, 32'd0);
        @(negedge clk);
        check("wrap1_a", {21'd0, w_a}, 32'h7FF);
        check("wrap1_pc", w_pc, 32'hFFFF_FFF8);
        check("wrap1_inst", w_inst, 32'h1000_07FE);
        @(negedge clk);
        check("wrap2_a", {21'd0, w_a}, 32'h000);
        check("wrap2_pc", w_pc, 32'hFFFF_FFFC);
        check("wrap2_inst", w_inst, 32'h1000_07FF);
        @(negedge clk);
        check("wrap3_a", {21'd0, w_a}, 32'h001);
        check("wrap3_pc", w_pc, 32'h0000_0000);
        check("wrap3_inst", w_inst, 32'h1000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
